// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO of {instr, err}.
// Define RANGE_CHECK_EN to flag out-of-range immediates; by default only illegal classes set out_err.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [3:0] CLS_R      = 4'd0;
    localparam logic [3:0] CLS_OPIMM  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        illegal;
    logic        push;
    logic        pop;
    logic [31:0] slot0_instr;
    logic        slot0_err;
    logic [31:0] slot1_instr;
    logic        slot1_err;

    always_comb begin
        enc_instr = '0;
        illegal   = 1'b0;
        case (in_class)
            CLS_R:      enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            CLS_OPIMM:  enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_OPIMM};
            CLS_LOAD:   enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            CLS_JALR:   enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_JALR};
            CLS_STORE:  enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            CLS_BRANCH: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                     in_imm[4:1], in_imm[11], OP_BRANCH};
            CLS_JAL:    enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                     in_rd, OP_JAL};
            CLS_LUI:    enc_instr = {in_imm[31:12], in_rd, OP_LUI};
            CLS_AUIPC:  enc_instr = {in_imm[31:12], in_rd, OP_AUIPC};
            default:    illegal   = 1'b1;
        endcase
    end

`ifdef RANGE_CHECK_EN
    logic range_bad;

    // A field fits when every bit above its top bit repeats the sign bit.
    always_comb begin
        range_bad = 1'b0;
        case (in_class)
            CLS_OPIMM, CLS_LOAD, CLS_JALR, CLS_STORE:
                range_bad = !((in_imm[31:11] == '0) || (in_imm[31:11] == '1));
            CLS_BRANCH:
                range_bad = !((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) || in_imm[0];
            CLS_JAL:
                range_bad = !((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) || in_imm[0];
            CLS_LUI, CLS_AUIPC:
                range_bad = (in_imm[11:0] != '0);
            default:
                range_bad = 1'b0;
        endcase
    end

    assign enc_err = illegal | range_bad;
`else
    logic unused_imm_lsb;

    assign unused_imm_lsb = in_imm[0];
    assign enc_err        = illegal;
`endif

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // in_ready/out_valid are flopped from the next state so neither depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            slot0_instr <= '0;
            slot0_err   <= 1'b0;
            slot1_instr <= '0;
            slot1_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        slot0_instr <= enc_instr;
                        slot0_err   <= enc_err;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        slot0_instr <= enc_instr;
                        slot0_err   <= enc_err;
                    end else if (push) begin
                        slot1_instr <= enc_instr;
                        slot1_err   <= enc_err;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        slot0_instr <= slot1_instr;
                        slot0_err   <= slot1_err;
                    end
                end
                default: ;
            endcase
            if (push && enc_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign out_instr = slot0_instr;
    assign out_err   = slot0_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder; expectations follow RANGE_CHECK_EN when it is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_class;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_cnt = 0;
    logic [32:0] sb[$];
    bit          rnd_done;

`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder built from shifts and signed ranges; returns {err, instr}.
    function automatic logic [32:0] model(input logic [3:0] c, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] imm);
        logic [31:0] w;
        logic        bad;
        logic        ill;
        int          s;
        s   = $signed(imm);
        w   = 32'd0;
        bad = 1'b0;
        ill = 1'b0;
        case (c)
            4'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | 32'h33;
            4'd1, 4'd2, 4'd6: begin
                w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7)
                    | (c == 4'd1 ? 32'h13 : (c == 4'd2 ? 32'h03 : 32'h67));
                bad = (s < -2048) || (s > 2047);
            end
            4'd3: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
                bad = (s < -2048) || (s > 2047);
            end
            4'd4: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                    | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | 32'h63;
                bad = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            4'd5: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'h6F;
                bad = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
            end
            4'd7, 4'd8: begin
                w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | (c == 4'd7 ? 32'h37 : 32'h17);
                bad = (imm % 4096 != 0);
            end
            default: ill = 1'b1;
        endcase
        return {ill | (RC & bad), w};
    endfunction

    // Pops the scoreboard whenever a word leaves the DUT at the coming edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got instr=%08h err=%0b, none expected", out_instr, out_err);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({out_err, out_instr} !== e) begin
                    errors++;
                    $display("FAIL sb_word: got instr=%08h err=%0b, expected instr=%08h err=%0b",
                             out_instr, out_err, e[31:0], e[32]);
                end
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [32:0] exp);
        bit ok;
        ok        = 1'b0;
        in_class  = c;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back(exp);
                if (exp[32] && exp_cnt < 255) exp_cnt++;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic wait_drain;
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && out_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left, required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({out_valid, in_ready, out_err, out_instr, err_cnt} !== {1'b0, 1'b1, 1'b0, 32'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: valid=%0b ready=%0b err=%0b instr=%08h cnt=%0d, required 0 1 0 00000000 0",
                     out_valid, in_ready, out_err, out_instr, err_cnt);
        end
    endtask

    task automatic test_latency;
        out_ready = 1'b1;
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, {1'b0, 32'h00500093});
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00500093 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL latency: valid=%0b instr=%08h err=%0b, required 1 00500093 0",
                     out_valid, out_instr, out_err);
        end
        wait_drain();
    endtask

    task automatic test_formats;
        out_ready = 1'b1;
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          {1'b0, 32'h002081B3});
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   {1'b0, 32'h123452B7});
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,          {1'b0, 32'h00208463});
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800,        {1'b0, 32'h001000EF});
        // STORE sw x2, -4(x1): imm=0xFFC
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC,   {1'b0, 32'hFE20AE23});
        wait_drain();
    endtask

    task automatic test_range;
        out_ready = 1'b1;
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, {RC, 32'h80000093});
        checks++;
        if (err_cnt !== (RC ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL imm2048_cnt: err_cnt=%0d, required %0d", err_cnt, RC ? 1 : 0);
        end
        send(4'd9, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFFFFFF, {1'b1, 32'h0});
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9,    {RC, 32'h00208463});
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h100000, {RC, 32'h800000EF});
        send(4'd8, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, {RC, 32'h00001117});
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, {1'b0, 32'h402081B3});
        wait_drain();
        checks++;
        if (err_cnt !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL range_cnt: err_cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd1, model(4'd1, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd1));
        send(4'd1, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'd2, model(4'd1, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'd2));
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: in_ready=%0b out_valid=%0b, required 0 1", in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_class = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_instr !== model(4'd1, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd1)) begin
            errors++;
            $display("FAIL full_hold: in_ready=%0b instr=%08h, required ready 0 and first word held",
                     in_ready, out_instr);
        end
        out_ready = 1'b1;
        send(4'd2, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, 32'd3, model(4'd2, 5'd3, 5'd4, 5'd0, 3'd2, 7'd0, 32'd3));
        wait_drain();
    endtask

    task automatic test_random;
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [3:0]  c;
                    logic [4:0]  rd;
                    logic [4:0]  r1;
                    logic [4:0]  r2;
                    logic [2:0]  f3;
                    logic [6:0]  f7;
                    logic [31:0] imm;
                    c   = 4'($urandom_range(0, 15));
                    rd  = 5'($urandom);
                    r1  = 5'($urandom);
                    r2  = 5'($urandom);
                    f3  = 3'($urandom);
                    f7  = 7'($urandom);
                    case ($urandom_range(0, 3))
                        0: imm = $urandom;
                        1: imm = 32'($signed(12'($urandom)));
                        2: imm = 32'($signed(21'($urandom))) & 32'hFFFFFFFE;
                        default: imm = $urandom & 32'hFFFFF000;
                    endcase
                    send(c, rd, r1, r2, f3, f7, imm, model(c, rd, r1, r2, f3, f7, imm));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (err_cnt !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL random_cnt: err_cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_full;
        out_ready = 1'b0;
        send(4'd9,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, {1'b1, 32'h0});
        send(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, {1'b1, 32'h0});
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_class  = 4'd15;
        out_ready = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, out_err, out_instr, err_cnt} !== {1'b0, 1'b1, 1'b0, 32'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_full: valid=%0b ready=%0b err=%0b instr=%08h cnt=%0d, required 0 1 0 00000000 0",
                     out_valid, in_ready, out_err, out_instr, err_cnt);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
                errors++;
                $display("FAIL stale_word: out_valid=%0b err_cnt=%0d, required 0 0", out_valid, err_cnt);
            end
        end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++)
            send(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, {1'b1, 32'h0});
        wait_drain();
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: err_cnt=%0d, required 255", err_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_class  = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_latency();
        test_formats();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_full();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
